// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction and data requesters.
// One outstanding access; valid pulses MEM_LAT+2 cycles after the request is seen idle; the loser stalls.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic       SRC_I = 1'b0;
  localparam logic       SRC_D = 1'b1;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       last_gnt;
  logic [3:0] lat_cnt;
  logic       grant_any;
  logic       grant_d;
  logic       lat_done;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | (last_gnt == SRC_I));
    lat_done  = (lat_cnt >= LAT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (lat_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en  = (state == S_ISSUE);
    i_valid = (state == S_DONE) && (owner == SRC_I);
    d_valid = (state == S_DONE) && (owner == SRC_D);
    i_stall = i_req & ~i_valid;
    d_stall = d_req & ~d_valid;
  end

  // Operands are captured at grant so requester-side changes after that are invisible to memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner    <= SRC_I;
      last_gnt <= SRC_I;
      lat_cnt  <= 4'd0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            if (grant_d) begin
              owner    <= SRC_D;
              last_gnt <= SRC_D;
              mem_we   <= d_we;
              mem_addr <= d_addr;
              mem_wd   <= d_wd;
            end else begin
              owner    <= SRC_I;
              last_gnt <= SRC_I;
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
              mem_wd   <= '0;
            end
          end
        end
        S_ISSUE: begin
          lat_cnt <= 4'd1;
        end
        S_WAIT: begin
          if (!lat_done) begin
            lat_cnt <= lat_cnt + 4'd1;
          end else if (owner == SRC_D) begin
            d_rdata <= mem_we ? '0 : mem_rdata;
          end else begin
            i_rdata <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  a_valid_exclusive: assert property (@(posedge clock) disable iff (reset) !(i_valid && d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus a fairness sequence.
module tb_mem_port_arbiter;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: data is addr^K two cycles after mem_en, junk otherwise.
  logic        s1_v, s2_v;
  logic [31:0] s1_a, s2_a;
  always @(posedge clock) begin
    s1_v <= mem_en;
    s1_a <= mem_addr;
    s2_v <= s1_v;
    s2_a <= s1_a;
  end
  assign mem_rdata = (s2_v === 1'b1) ? (s2_a ^ K) : 32'h0BAD0BAD;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [133:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwe, input logic [31:0] daddr,
                             input logic [31:0] dwd,
                             input logic iv, input logic dv, input logic is, input logic ds,
                             input logic en, input logic we, input logic [31:0] maddr,
                             input logic [31:0] mwd, input logic [31:0] ird, input logic [31:0] drd);
    vec_t r;
    r.rst = rst; r.ireq = ireq; r.iaddr = iaddr;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwd = dwd;
    r.exp = {iv, dv, is, ds, en, we, maddr, mwd, ird, drd};
    return r;
  endfunction

  function automatic logic [133:0] outs();
    return {i_valid, d_valid, i_stall, d_stall, mem_en, mem_we, mem_addr, mem_wd, i_rdata, d_rdata};
  endfunction

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    reset  = r.rst;
    i_req  = r.ireq;
    i_addr = r.iaddr;
    d_req  = r.dreq;
    d_we   = r.dwe;
    d_addr = r.daddr;
    d_wd   = r.dwd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    logic exp_d;
    logic [31:0] exp_rd;

    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;

    // Single instruction read after reset.
    vecs.push_back(v(0,1,'h10,0,0,0,0,          0,0,1,0, 0,0,'h10*0,0,0,0));
    vecs.push_back(v(0,1,'h10,0,0,0,0,          0,0,1,0, 1,0,'h10,0,0,0));
    vecs.push_back(v(0,1,'h10,0,0,0,0,          0,0,1,0, 0,0,'h10,0,0,0));
    vecs.push_back(v(0,1,'h10,0,0,0,0,          0,0,1,0, 0,0,'h10,0,0,0));
    vecs.push_back(v(0,1,'h10,0,0,0,0,          1,0,0,0, 0,0,'h10,0,'hA5A5A5B5,0));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,0,'h10,0,'hA5A5A5B5,0));
    // Reset, then both requesters rise together: D wins first.
    vecs.push_back(v(1,0,0,0,0,0,0,             0,0,0,0, 0,0,'h10,0,'hA5A5A5B5,0));
    vecs.push_back(v(0,1,'h40,1,0,'h80,0,       0,0,1,1, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,'h40,1,0,'h80,0,       0,0,1,1, 1,0,'h80,0,0,0));
    vecs.push_back(v(0,1,'h40,1,0,'h80,0,       0,0,1,1, 0,0,'h80,0,0,0));
    vecs.push_back(v(0,1,'h40,1,0,'h80,0,       0,0,1,1, 0,0,'h80,0,0,0));
    vecs.push_back(v(0,1,'h40,1,0,'h80,0,       0,1,1,0, 0,0,'h80,0,0,'hA5A5A525));
    vecs.push_back(v(0,1,'h40,0,0,0,0,          0,0,1,0, 0,0,'h80,0,0,'hA5A5A525));
    vecs.push_back(v(0,1,'h40,0,0,0,0,          0,0,1,0, 1,0,'h40,0,0,'hA5A5A525));
    vecs.push_back(v(0,1,'h40,0,0,0,0,          0,0,1,0, 0,0,'h40,0,0,'hA5A5A525));
    vecs.push_back(v(0,1,'h40,0,0,0,0,          0,0,1,0, 0,0,'h40,0,0,'hA5A5A525));
    vecs.push_back(v(0,1,'h40,0,0,0,0,          1,0,0,0, 0,0,'h40,0,'hA5A5A5E5,'hA5A5A525));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,0,'h40,0,'hA5A5A5E5,'hA5A5A525));
    // Data write; d_addr changes after grant and must not reach mem_addr.
    vecs.push_back(v(0,0,0,1,1,'h200,'hDEADBEEF, 0,0,0,1, 0,0,'h40,0,'hA5A5A5E5,'hA5A5A525));
    vecs.push_back(v(0,0,0,1,1,'h999,'hDEADBEEF, 0,0,0,1, 1,1,'h200,'hDEADBEEF,'hA5A5A5E5,'hA5A5A525));
    vecs.push_back(v(0,0,0,1,1,'h999,'hDEADBEEF, 0,0,0,1, 0,1,'h200,'hDEADBEEF,'hA5A5A5E5,'hA5A5A525));
    vecs.push_back(v(0,0,0,1,1,'h999,'hDEADBEEF, 0,0,0,1, 0,1,'h200,'hDEADBEEF,'hA5A5A5E5,'hA5A5A525));
    vecs.push_back(v(0,0,0,1,1,'h999,'hDEADBEEF, 0,1,0,0, 0,1,'h200,'hDEADBEEF,'hA5A5A5E5,0));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,1,'h200,'hDEADBEEF,'hA5A5A5E5,0));
    // Reset during WAIT aborts the read; a later read completes normally.
    vecs.push_back(v(0,1,'h300,0,0,0,0,         0,0,1,0, 0,1,'h200,'hDEADBEEF,'hA5A5A5E5,0));
    vecs.push_back(v(0,1,'h300,0,0,0,0,         0,0,1,0, 1,0,'h300,0,'hA5A5A5E5,0));
    vecs.push_back(v(1,1,'h300,0,0,0,0,         0,0,1,0, 0,0,'h300,0,'hA5A5A5E5,0));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,'h20,0,0,0,0,          0,0,1,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,'h20,0,0,0,0,          0,0,1,0, 1,0,'h20,0,0,0));
    vecs.push_back(v(0,1,'h20,0,0,0,0,          0,0,1,0, 0,0,'h20,0,0,0));
    vecs.push_back(v(0,1,'h20,0,0,0,0,          0,0,1,0, 0,0,'h20,0,0,0));
    vecs.push_back(v(0,1,'h20,0,0,0,0,          1,0,0,0, 0,0,'h20,0,'hA5A5A585,0));
    vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,0, 0,0,'h20,0,'hA5A5A585,0));

    repeat (3) @(posedge clock);
    #2;
    check("reset_state", outs(), 134'd0);

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clock);
      #1;
      drive(vecs[r]);
      #1;
      check($sformatf("row%0d", r), outs(), vecs[r].exp);
    end

    // Both requesters held continuously: grants must alternate D,I,D,I,D,I.
    @(posedge clock);
    #1;
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_addr = 32'h2000; d_wd = 32'h0;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 200) begin
      @(posedge clock);
      #2;
      cyc++;
      if (i_valid || d_valid) begin
        exp_d  = (n % 2 == 0);
        exp_rd = (exp_d ? d_addr : i_addr) ^ K;
        check($sformatf("fair_order%0d", n), {132'd0, i_valid, d_valid}, {132'd0, ~exp_d, exp_d});
        check($sformatf("fair_rdata%0d", n), {102'd0, d_valid ? d_rdata : i_rdata}, {102'd0, exp_rd});
        if (d_valid) d_addr = d_addr + 32'd4;
        if (i_valid) i_addr = i_addr + 32'd4;
        n++;
      end
    end
    if (n < 6) begin
      checks++;
      errors++;
      $display("FAIL fair_timeout: got %0d transactions expected 6", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory (BRAM/DDR front-end, fixed read latency) between the instruction-fetch requester and the data/MMIO requester of the core.
- Serialises accesses with one outstanding transaction, round-robin fairness, and per-requester stall and valid handshakes.
- Sits between the core's memory masters and the physical memory port.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to the mem_rdata valid cycle; legal range 1..15

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request; held until i_valid
- i_addr  in  ADDR_W  instruction address
- i_valid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  fetched word
- i_stall  out  1  i_req & ~i_valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wd  in  DATA_W  write data
- d_valid  out  1  one-cycle pulse; read data valid or write acknowledged
- d_rdata  out  DATA_W  read word; 0 for writes
- d_stall  out  1  d_req & ~d_valid
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Internal registers: owner (I/D), last_gnt (I/D), 4-bit lat_cnt.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: grant that requester.
  - Both req: grant the requester not equal to last_gnt.
  - On grant: latch addr, we and wd (instr: we=0, wd=0) into the mem_* registers, set owner, set last_gnt=owner, go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle; lat_cnt<=1; go to WAIT.
- WAIT:
  - While lat_cnt<MEM_LAT: lat_cnt++.
  - When lat_cnt==MEM_LAT: capture mem_rdata (0 if mem_we) into the owner's rdata register; go to DONE.
- DONE:
  - Owner's valid=1 for this cycle only; go to IDLE.
  - The requester drops req in the next cycle, or keeps it high with new operands to start a back-to-back request. That request is sampled in IDLE, so the minimum spacing between issues is MEM_LAT+3 cycles.
- Latency: request seen in IDLE at cycle T → mem_en at T+1 → rdata captured at T+1+MEM_LAT → valid at T+2+MEM_LAT.
- Requester-side changes: requester operands may change after the grant without affecting mem_*. A req deasserted before its valid is a protocol violation; the transaction still completes and valid still pulses.
- Outputs outside ISSUE: mem_addr, mem_wd and mem_we hold their latched values; only mem_en is 0.
- rdata outputs hold their last captured value until the next completion for that requester.
- Stall: i_stall and d_stall are combinational. A requester that is not granted stalls through the whole other transaction.
- Reset (any state, including mid-transaction):
  - Next state IDLE; last_gnt=I, so D wins the first tie.
  - lat_cnt=0.
  - mem_en, mem_we, mem_addr, mem_wd = 0.
  - i_valid, d_valid = 0; i_rdata, d_rdata = 0.
  - An aborted transaction never produces valid.
  - mem_rdata arriving after reset is ignored.
- No write buffering and no read/write forwarding: ordering equals grant order.

Test Plan:
- MEM_LAT=2; model memory returns mem_rdata=addr^32'hA5A5A5A5 two cycles after mem_en. After reset, i_req=1, i_addr=0x10 at T0 → mem_en only at T1 with mem_addr=0x10; i_valid at T4 with i_rdata=0xA5A5A5B5; i_stall=1 for T0..T3.
- i_req and d_req both rise in the first cycle after reset → D granted first (mem_en at T1), I's mem_en at T6, d_valid at T4, i_valid at T9.
- Both reqs held continuously with new operands after each valid for 6 transactions → grant order D,I,D,I,D,I and no requester starves.
- d_req=1, d_we=1, d_addr=0x200, d_wd=0xDEADBEEF → mem_en=1, mem_we=1, mem_addr=0x200, mem_wd=0xDEADBEEF for one cycle; d_valid pulse with d_rdata=0.
- Assert reset in WAIT after mem_en → no i_valid/d_valid, all outputs 0 next cycle; a subsequent i_req completes normally with correct data.
- Change d_addr to 0x999 in the cycle after grant (req held) → mem_addr stays at the latched value.
